// File: rtl/neural_network.sv
// 6-3-3 MLP inference engine (IEEE-754 single, truncating) on one serial MAC datapath.
// Optional macro NN_OUTPUT_RELU_EN applies ReLU to the output layer as well.
module neural_network #(
  parameter logic [575:0] W1 = {{2{32'h3F800000}}, {6{32'h0}}, {2{32'h3F800000}},
                                {6{32'h0}}, {2{32'h3F800000}}},
  parameter logic [95:0]  B1 = 96'h0,
  parameter logic [287:0] W2 = {32'h3F800000, {3{32'h0}}, 32'h3F800000,
                                {3{32'h0}}, 32'h3F800000},
  parameter logic [95:0]  B2 = 96'h0
) (
  input  logic        clk_x70,
  input  logic        rst_x70,
  input  logic        start_x70,
  input  logic [31:0] x1_x70,
  input  logic [31:0] x2_x70,
  input  logic [31:0] x3_x70,
  input  logic [31:0] x4_x70,
  input  logic [31:0] x5_x70,
  input  logic [31:0] x6_x70,
  output logic        done_x70,
  output logic [31:0] y1_x70,
  output logic [31:0] y2_x70,
  output logic [31:0] y3_x70
);

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

  function automatic logic [31:0] relu(input logic [31:0] v);
    return v[31] ? 32'h0 : v;
  endfunction

  // Denormal operands flush to zero; product mantissa is truncated.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] prod;
    logic [22:0] m;
    int          e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e    = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin
      m = prod[46:24];
      e = e + 1;
    end else begin
      m = prod[45:23];
    end
    if (e <= 0)   return 32'h0;
    if (e >= 255) return {a[31] ^ b[31], 8'hFF, 23'h0};
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  // 26 guard bits plus a sticky bit keep the truncated result exact in magnitude.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p, q;
    logic [50:0] mp, mq, sum, norm;
    logic [7:0]  d;
    logic        sticky, az, bz;
    int          pos, e;
    az = (a[30:23] == 8'd0);
    bz = (b[30:23] == 8'd0);
    if (az && bz) return 32'h0;
    if (az)       return b;
    if (bz)       return a;
    if (a[30:0] >= b[30:0]) begin
      p = a; q = b;
    end else begin
      p = b; q = a;
    end
    d  = p[30:23] - q[30:23];
    mp = {2'b01, p[22:0], 26'h0};
    mq = {2'b01, q[22:0], 26'h0};
    if (d > 8'd50) begin
      sticky = 1'b1;
      mq     = '0;
    end else begin
      sticky = |(mq & ((51'd1 << d) - 51'd1));
      mq     = mq >> d;
    end
    mq[0] = mq[0] | sticky;
    sum   = (p[31] == q[31]) ? mp + mq : mp - mq;
    if (sum == '0) return 32'h0;
    pos = 0;
    for (int i = 0; i < 51; i++) if (sum[i]) pos = i;
    e    = int'(p[30:23]) + pos - 49;
    norm = sum << (50 - pos);
    if (e <= 0)   return 32'h0;
    if (e >= 255) return {p[31], 8'hFF, 23'h0};
    return {p[31], e[7:0], norm[49:27]};
  endfunction

  function automatic logic [31:0] out_act(input logic [31:0] v);
`ifdef NN_OUTPUT_RELU_EN
    return relu(v);
`else
    return v;
`endif
  endfunction

  logic [17:0][31:0] w1_a;
  logic [8:0][31:0]  w2_a;
  logic [2:0][31:0]  b1_a, b2_a;
  assign w1_a = W1;
  assign w2_a = W2;
  assign b1_a = B1;
  assign b2_a = B2;

  state_t           state;
  logic [5:0][31:0] x_q;
  logic [2:0][31:0] h_q;
  logic [1:0][31:0] y_q;
  logic [31:0]      acc;
  logic [4:0]       cnt;
  logic [2:0]       term;
  logic [1:0]       nrn;

  logic [31:0] w_sel, in_sel, bias_sel, prod, sum;
  logic        last;

  always_comb begin
    w_sel    = (state == L1) ? w1_a[cnt] : w2_a[cnt[3:0]];
    in_sel   = (state == L1) ? x_q[term] : h_q[term[1:0]];
    bias_sel = (state == L1) ? b1_a[nrn] : b2_a[nrn];
    last     = (state == L1) ? (term == 3'd5) : (term == 3'd2);
    prod     = fp_mul(w_sel, in_sel);
    sum      = fp_add((term == 3'd0) ? bias_sel : acc, prod);
  end

  always_ff @(posedge clk_x70) begin
    if (rst_x70) begin
      state    <= IDLE;
      done_x70 <= 1'b0;
      y1_x70   <= '0;
      y2_x70   <= '0;
      y3_x70   <= '0;
      x_q      <= '0;
      h_q      <= '0;
      y_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      term     <= '0;
      nrn      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_x70 <= 1'b0;
          if (start_x70) begin
            x_q   <= {x6_x70, x5_x70, x4_x70, x3_x70, x2_x70, x1_x70};
            cnt   <= '0;
            term  <= '0;
            nrn   <= '0;
            state <= L1;
          end
        end
        L1: begin
          acc <= sum;
          cnt <= cnt + 5'd1;
          if (last) begin
            h_q[nrn] <= relu(sum);
            term     <= '0;
            if (nrn == 2'd2) begin
              nrn   <= '0;
              cnt   <= '0;
              state <= L2;
            end else begin
              nrn <= nrn + 2'd1;
            end
          end else begin
            term <= term + 3'd1;
          end
        end
        L2: begin
          acc <= sum;
          cnt <= cnt + 5'd1;
          if (last) begin
            term <= '0;
            // Results are staged internally so the outputs only move at completion.
            if (nrn == 2'd2) begin
              y1_x70   <= y_q[0];
              y2_x70   <= y_q[1];
              y3_x70   <= out_act(sum);
              done_x70 <= 1'b1;
              state    <= DONE;
            end else begin
              y_q[nrn[0]] <= out_act(sum);
              nrn         <= nrn + 2'd1;
            end
          end else begin
            term <= term + 3'd1;
          end
        end
        DONE: begin
          done_x70 <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neural_network.sv
// Directed scoreboard bench for neural_network; a second instance carries B2 = {-1,0,0}.
module tb_neural_network;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0, x5 = '0, x6 = '0;
  logic        done, done_b;
  logic [31:0] y1, y2, y3, yb1, yb2, yb3;

  int applied = 0, miscompares = 0;

  typedef struct {
    logic [31:0] y1, y2, y3, yb1;
  } exp_t;
  exp_t sb[$];

  localparam logic [95:0] B2_ALT = {32'h0, 32'h0, 32'hBF800000};
`ifdef NN_OUTPUT_RELU_EN
  localparam logic [31:0] NEG1_OUT = 32'h00000000;
`else
  localparam logic [31:0] NEG1_OUT = 32'hBF800000;
`endif

  always #5 clk = ~clk;

  neural_network dut (
    .clk_x70(clk), .rst_x70(rst), .start_x70(start),
    .x1_x70(x1), .x2_x70(x2), .x3_x70(x3), .x4_x70(x4), .x5_x70(x5), .x6_x70(x6),
    .done_x70(done), .y1_x70(y1), .y2_x70(y2), .y3_x70(y3)
  );

  neural_network #(.B2(B2_ALT)) dut_b (
    .clk_x70(clk), .rst_x70(rst), .start_x70(start),
    .x1_x70(x1), .x2_x70(x2), .x3_x70(x3), .x4_x70(x4), .x5_x70(x5), .x6_x70(x6),
    .done_x70(done_b), .y1_x70(yb1), .y2_x70(yb2), .y3_x70(yb3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    applied++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic [31:0] a, b, c, d, e, f);
    x1 = a; x2 = b; x3 = c; x4 = d; x5 = e; x6 = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat counts edges after the start edge; outputs must not move before done.
  task automatic wait_done(input int lat0, output int lat, output logic moved);
    logic [31:0] y1p;
    lat   = lat0;
    moved = 1'b0;
    y1p   = y1;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (done !== 1'b1 && y1 !== y1p) moved = 1'b1;
    end
  endtask

  task automatic check_vec(input string tag, input int lat, input logic moved);
    exp_t e;
    chk({tag, " latency"}, 32'(lat), 32'd27);
    chk({tag, " stable"}, 32'(moved), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " y1"}, y1, e.y1);
      chk({tag, " y2"}, y2, e.y2);
      chk({tag, " y3"}, y3, e.y3);
      chk({tag, " yb1"}, yb1, e.yb1);
    end
    @(negedge clk);
    chk({tag, " done width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int   lat, extra;
    logic moved;

    repeat (3) @(negedge clk);
    chk("rst y1", y1, 32'h0);
    chk("rst y2", y2, 32'h0);
    chk("rst y3", y3, 32'h0);
    chk("rst done", 32'(done), 32'd0);
    rst = 1'b0;

    sb.push_back('{32'h40400000, 32'h3F400000, 32'h0, 32'h40000000});
    kick(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3E800000, 32'hC0400000, 32'h3F800000);
    wait_done(0, lat, moved);
    check_vec("basic", lat, moved);

    sb.push_back('{32'h0, 32'h0, 32'h0, NEG1_OUT});
    kick(32'hBF800000, 32'h3F000000, 32'h0, 32'h0, 32'h0, 32'h0);
    wait_done(0, lat, moved);
    check_vec("relu", lat, moved);

    sb.push_back('{32'h0, 32'h0, 32'h0, NEG1_OUT});
    kick(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    wait_done(0, lat, moved);
    check_vec("zeros", lat, moved);

    sb.push_back('{32'h0, 32'h0, 32'h0, NEG1_OUT});
    kick(32'h00000001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    wait_done(0, lat, moved);
    check_vec("denorm", lat, moved);

    sb.push_back('{32'h40400000, 32'h42480000, 32'h40F00000, 32'h40000000});
    kick(32'h3FC00000, 32'h3FC00000, 32'h42C80000, 32'hC2480000, 32'h40E00000, 32'h3F000000);
    wait_done(0, lat, moved);
    check_vec("mixed", lat, moved);

    // 1 + 1.5*2^-24 truncates to 1.0; -1 + 1 must give +0.
    sb.push_back('{32'h3F800000, 32'h3F800000, 32'h0, 32'h0});
    kick(32'h3F800000, 32'h33C00000, 32'h3F800000, 32'h33C00000, 32'h0, 32'h0);
    wait_done(0, lat, moved);
    check_vec("trunc", lat, moved);

    // Inputs change and start pulses during L1: the first latch must win.
    sb.push_back('{32'h40400000, 32'h3F400000, 32'h0, 32'h40000000});
    kick(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3E800000, 32'hC0400000, 32'h3F800000);
    repeat (4) @(negedge clk);
    x1 = 32'h42C80000; x3 = 32'hC2480000; x5 = 32'h40E00000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, lat, moved);
    check_vec("glitch", lat, moved);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk("glitch extra done", 32'(extra), 32'd0);

    // Reset at cycle 10 of a run aborts it and clears outputs.
    kick(32'h3FC00000, 32'h3FC00000, 32'h42C80000, 32'hC2480000, 32'h40E00000, 32'h3F000000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    chk("abort done", 32'(extra), 32'd0);
    chk("abort y1", y1, 32'h0);
    chk("abort y2", y2, 32'h0);
    chk("abort y3", y3, 32'h0);
    chk("abort yb1", yb1, 32'h0);

    sb.push_back('{32'h40400000, 32'h42480000, 32'h40F00000, 32'h40000000});
    kick(32'h3FC00000, 32'h3FC00000, 32'h42C80000, 32'hC2480000, 32'h40E00000, 32'h3F000000);
    wait_done(0, lat, moved);
    check_vec("after abort", lat, moved);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
